cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//  Memory-side responder for the cache mem request interface (mem_ce/mem_we/mem_addr/...) driven by ICache/DCache.
//  Accepts one transaction at a time: a read returns a full cache-line burst; a write is single-word, byte-masked.
//  Backed by an internal word-addressed SRAM with programmable access latency; sits below the caches in sim/FPGA top.
// PARAMETERS
//  BUS_WIDTH       32   address width
//  DATA_WIDTH      32   data word width (multiple of 8)
//  BURST_LEN       16   words per read burst (= cache line words, power of 2, >=2)
//  MEM_DEPTH_LOG2  12   log2 of SRAM depth in words
//  LATENCY         2    cycles from accept to first rdata beat / write response (>=1)
// PORTS
//  clk               in   1               clock, all logic on rising edge
//  reset             in   1               asynchronous, active-low reset
//  mem_ce            in   1               request valid, sampled only in IDLE
//  mem_we            in   1               0 = line read, 1 = word write
//  mem_addr          in   BUS_WIDTH       byte address
//  mem_wdata         in   DATA_WIDTH      write data
//  mem_wmask         in   DATA_WIDTH/8    byte-enable, bit i -> byte i
//  mem_rdata         out  DATA_WIDTH      read beat data
//  mem_rdata_valid   out  1               read beat valid, one beat per cycle
//  mem_write_respone out  1               1-cycle pulse: write committed
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, counters=0, mem_rdata=0, mem_rdata_valid=0, mem_write_respone=0; SRAM contents kept.
//  Word index = mem_addr[MEM_DEPTH_LOG2+1:2]; upper address bits ignored (aliasing); mem_addr[1:0] ignored.
//  FSM: IDLE -> WAIT -> (RBURST | WRESP) -> IDLE.
//   IDLE: if mem_ce, capture we, addr, wdata, wmask; lat_cnt<=LATENCY-1; go WAIT.
//   WAIT: decrement lat_cnt; at lat_cnt==0 go RBURST (read) or WRESP (write).
//   RBURST: base = captured index with low log2(BURST_LEN) bits cleared; beat k (k=0..BURST_LEN-1)
//     drives mem_rdata=SRAM[base+k], mem_rdata_valid=1, one beat/cycle, no gaps; beat BURST_LEN-1 -> IDLE.
//     Beat index wraps inside the line only; base+k never crosses a line boundary.
//   WRESP: SRAM[idx] bytes with wmask=1 updated with wdata, others unchanged; mem_write_respone=1 this cycle; -> IDLE.
//  Latency: mem_ce seen in IDLE at cycle T -> first read beat or write response at cycle T+LATENCY+1; last beat at T+LATENCY+BURST_LEN.
//  wmask==0 write: no byte changes, response still pulsed.
//  mem_ce while not IDLE: ignored (no queueing); caller holds/reasserts after completion. Back-to-back: IDLE re-entered,
//   a held mem_ce is accepted the cycle after the last beat/response (1 idle cycle minimum between transactions).
//  mem_rdata outside RBURST = 0; mem_rdata_valid and mem_write_respone never both 1.
//  Reset mid-burst/mid-wait: transaction dropped, outputs 0 immediately; pending write not committed if in WAIT.
//  No backpressure: caller must accept every beat (matches cache read_count sequencing).
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/WAIT/RBURST/WRESP), mem op codes (READ=0, WRITE=1), default BURST_LEN.
//  Sub-module mem_sram_array: 1R1W sync SRAM, byte write enables, registered read (1-cycle); responder issues read
//   address one cycle ahead of each beat so beats stay contiguous.
//  Top: FSM, lat_cnt ($clog2(LATENCY+1) bits), beat_cnt ($clog2(BURST_LEN) bits), request capture regs.
// TESTING
//  1 Write 0xDEADBEEF @0x40 mask 0xF -> mem_write_respone pulse at T+3 (LATENCY=2); read @0x40 -> beat0=0xDEADBEEF.
//  2 Preload words 0x100..0x13C with index values; read @0x128 -> 16 contiguous beats, data 0x40..0x4F, valid exactly 16 cycles.
//  3 Byte mask: word=0x11223344, write 0xAABBCCDD mask 0b0101 -> read back 0x11BB33DD.
//  4 mem_ce held high throughout -> ce in RBURST ignored; next read accepted 1 cycle after last beat; no overlap.
//  5 Assert reset at beat 5 of burst -> mem_rdata_valid=0 same cycle, state IDLE; fresh read after release behaves as test 2.
//  6 Alias: write @(1<<(MEM_DEPTH_LOG2+2))+0x8 -> visible reading @0x8; wmask=0 write leaves data, still responds.

Source files
------------

// File: rtl/cache_mem_responder_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : cache_mem_responder_pkg
// Brief  : Shared types for the cache memory responder: FSM state encoding,
//          memory op codes and the default line burst length.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package cache_mem_responder_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RBURST = 2'd2,
      ST_WRESP  = 2'd3
   } state_t;

   // Request op carried on mem_we
   typedef enum logic {
      MEM_OP_READ  = 1'b0,
      MEM_OP_WRITE = 1'b1
   } mem_op_t;

   // Words per read burst, equal to the cache line size in words
   localparam int unsigned C_DEFAULT_BURST_LEN = 16;

endpackage
`default_nettype wire

// File: rtl/cache_mem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : cache_mem_responder_if
// Brief  : Cache-to-memory request/response bus. The cache side is the
//          master, the memory responder is the slave.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
interface cache_mem_responder_if #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    mem_ce;
   logic                    mem_we;
   logic [BUS_WIDTH-1:0]    mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH/8-1:0] mem_wmask;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_rdata_valid;
   logic                    mem_write_respone;

   modport master (
      output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_rdata_valid, mem_write_respone
   );

   modport slave (
      input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_rdata_valid, mem_write_respone
   );
endinterface
`default_nettype wire

// File: rtl/cache_mem_responder_sram.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : cache_mem_responder_sram
// Brief  : 1R1W synchronous word SRAM with per-byte write enables and a
//          registered (1-cycle) read port. Contents are never reset.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module cache_mem_responder_sram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12
)(
   input  logic                    clk,
   input  logic                    i_we,
   input  logic [ADDR_WIDTH-1:0]   i_waddr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wmask,
   input  logic                    i_re,
   input  logic [ADDR_WIDTH-1:0]   i_raddr,
   output logic [DATA_WIDTH-1:0]   o_rdata
);
   localparam int unsigned c_mask_w = DATA_WIDTH / 8;
   localparam int unsigned c_depth  = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Byte-masked write and registered read share the clock edge
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < c_mask_w; b++) begin
            if (i_wmask[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : cache_mem_responder
// Brief  : Memory-side responder for the cache request bus. One transaction
//          at a time: line reads return a BURST_LEN word burst, writes are
//          single-word and byte-masked. Fixed programmable access latency.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module cache_mem_responder
   import cache_mem_responder_pkg::*;
#(
   parameter int unsigned BUS_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BURST_LEN      = C_DEFAULT_BURST_LEN,
   parameter int unsigned MEM_DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY        = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   cache_mem_responder_if.slave bus
);
   localparam int unsigned c_lat_w  = $clog2(LATENCY + 1);
   localparam int unsigned c_beat_w = $clog2(BURST_LEN);
   localparam int unsigned c_mask_w = DATA_WIDTH / 8;
   localparam logic [c_lat_w-1:0]  c_lat_init  = c_lat_w'(LATENCY - 1);
   localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BURST_LEN - 1);

   state_t                    r_state;
   mem_op_t                   r_op;
   logic [c_lat_w-1:0]        r_lat;
   logic [c_beat_w-1:0]       r_beat;
   logic [MEM_DEPTH_LOG2-1:0] r_idx;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [c_mask_w-1:0]       r_wmask;
   logic                      r_valid;
   logic                      r_wresp;

   logic [MEM_DEPTH_LOG2-1:0] w_req_idx;
   logic [MEM_DEPTH_LOG2-1:0] w_raddr;
   logic [DATA_WIDTH-1:0]     w_sram_q;
   logic                      w_unused_addr;

   // Word index: byte offset dropped, upper bits alias onto the array
   assign w_req_idx     = bus.mem_addr[MEM_DEPTH_LOG2+1:2];
   assign w_unused_addr = ^{bus.mem_addr[BUS_WIDTH-1:MEM_DEPTH_LOG2+2], bus.mem_addr[1:0]};

   // Beat address stays inside the line: only the low bits follow the beat count
   assign w_raddr = {r_idx[MEM_DEPTH_LOG2-1:c_beat_w], r_beat};

   // Request FSM with latency and beat counters; outputs registered one stage after state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_op    <= MEM_OP_READ;
         r_lat   <= '0;
         r_beat  <= '0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_valid <= 1'b0;
         r_wresp <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_wresp <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.mem_ce) begin
                  r_op    <= mem_op_t'(bus.mem_we);
                  r_idx   <= w_req_idx;
                  r_wdata <= bus.mem_wdata;
                  r_wmask <= bus.mem_wmask;
                  r_lat   <= c_lat_init;
                  r_beat  <= '0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_lat == '0) begin
                  r_state <= (r_op == MEM_OP_WRITE) ? ST_WRESP : ST_RBURST;
               end else begin
                  r_lat <= r_lat - c_lat_w'(1);
               end
            end
            ST_RBURST: begin
               // SRAM read issued this cycle lands together with r_valid
               r_valid <= 1'b1;
               r_beat  <= r_beat + c_beat_w'(1);
               if (r_beat == c_last_beat) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WRESP: begin
               r_wresp <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   cache_mem_responder_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MEM_DEPTH_LOG2)
   ) u_sram (
      .clk     (clk),
      .i_we    (r_state == ST_WRESP),
      .i_waddr (r_idx),
      .i_wdata (r_wdata),
      .i_wmask (r_wmask),
      .i_re    (r_state == ST_RBURST),
      .i_raddr (w_raddr),
      .o_rdata (w_sram_q)
   );

   // Read data is forced to zero outside a burst and clears with reset
   assign bus.mem_rdata         = r_valid ? w_sram_q : '0;
   assign bus.mem_rdata_valid   = r_valid;
   assign bus.mem_write_respone = r_wresp;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module : tb_cache_mem_responder
// Brief  : Self-checking bench for cache_mem_responder with a word-array
//          reference model of the memory and timing expectations.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cache_mem_responder;
   localparam int L  = 2;
   localparam int B  = 16;
   localparam int DL = 12;

   typedef logic [31:0] line_t [B];

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] ref_mem   [0:(1<<DL)-1];
   bit          ref_known [0:(1<<DL)-1];

   cache_mem_responder_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus ();

   cache_mem_responder #(
      .BUS_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(B),
      .MEM_DEPTH_LOG2(DL), .LATENCY(L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % (1 << DL));
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int i;
      i = widx(a);
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[i][b*8 +: 8] = d[b*8 +: 8];
      if (m == 4'hF) ref_known[i] = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int lat);
      @(negedge clk);
      bus.mem_ce = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = a;
      bus.mem_wdata = d; bus.mem_wmask = m;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ce = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (bus.mem_write_respone === 1'b1) lat = n;
      end
      model_write(a, d, m);
   endtask

   task automatic do_read(input logic [31:0] a, output line_t beats, output int first,
                          output int nv, output bit contig, output bit clean);
      int last;
      @(negedge clk);
      bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = a;
      bus.mem_wdata = $urandom; bus.mem_wmask = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      bus.mem_ce = 1'b0;
      first = -1; nv = 0; contig = 1'b1; clean = 1'b1; last = -1;
      for (int k = 0; k < B; k++) beats[k] = 'x;
      for (int n = 1; n <= L + B + 3; n++) begin
         @(posedge clk); #1;
         if (bus.mem_rdata_valid === 1'b1) begin
            if (nv < B) beats[nv] = bus.mem_rdata;
            if (first < 0) first = n;
            else if (n != last + 1) contig = 1'b0;
            last = n;
            nv++;
            if (bus.mem_write_respone !== 1'b0) clean = 1'b0;
         end else if (bus.mem_rdata !== 32'h0) begin
            clean = 1'b0;
         end
      end
   endtask

   // Compare each known word of the addressed line against the model
   task automatic check_line(input string name, input logic [31:0] a, input line_t beats);
      int base;
      base = widx(a) & ~(B - 1);
      for (int k = 0; k < B; k++) begin
         if (ref_known[base + k]) begin
            checks++;
            if (beats[k] !== ref_mem[base + k]) begin
               failures++;
               $display("FAIL %s beat%0d got=%h exp=%h", name, k, beats[k], ref_mem[base + k]);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.mem_ce = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
      bus.mem_wdata = '0; bus.mem_wmask = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.mem_rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.mem_rdata_valid); end
      checks++;
      if (bus.mem_write_respone !== 1'b0) begin failures++; $display("FAIL reset_wresp got=%b exp=0", bus.mem_write_respone); end
      checks++;
      if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.mem_rdata); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      int lat, first, nv; bit contig, clean; line_t beats;
      do_write(32'h40, 32'hDEADBEEF, 4'hF, lat);
      checks++;
      if (lat !== L + 1) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, L + 1); end
      @(posedge clk); #1;
      checks++;
      if (bus.mem_write_respone !== 1'b0) begin failures++; $display("FAIL wr_pulse_width got=%b exp=0", bus.mem_write_respone); end
      do_read(32'h40, beats, first, nv, contig, clean);
      checks++;
      if (beats[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_readback got=%h exp=deadbeef", beats[0]); end
      checks++;
      if (first !== L + 1) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", first, L + 1); end
   endtask

   task automatic test_burst();
      int lat, first, nv; bit contig, clean; line_t beats;
      for (int i = 0; i < B; i++) do_write(32'h100 + 32'(4*i), 32'h40 + 32'(i), 4'hF, lat);
      do_read(32'h128, beats, first, nv, contig, clean);
      checks++;
      if (nv !== B) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", nv, B); end
      checks++;
      if (contig !== 1'b1) begin failures++; $display("FAIL burst_contig got=%b exp=1", contig); end
      checks++;
      if (clean !== 1'b1) begin failures++; $display("FAIL burst_idle_clean got=%b exp=1", clean); end
      checks++;
      if (first !== L + 1) begin failures++; $display("FAIL burst_first got=%0d exp=%0d", first, L + 1); end
      for (int k = 0; k < B; k++) begin
         checks++;
         if (beats[k] !== 32'h40 + 32'(k)) begin
            failures++; $display("FAIL burst_data%0d got=%h exp=%h", k, beats[k], 32'h40 + 32'(k));
         end
      end
   endtask

   task automatic test_mask();
      int lat, first, nv; bit contig, clean; line_t beats;
      do_write(32'h200, 32'h11223344, 4'hF, lat);
      do_write(32'h200, 32'hAABBCCDD, 4'b0101, lat);
      checks++;
      if (lat !== L + 1) begin failures++; $display("FAIL mask_latency got=%0d exp=%0d", lat, L + 1); end
      do_read(32'h200, beats, first, nv, contig, clean);
      checks++;
      if (beats[0] !== 32'h11BB33DD) begin failures++; $display("FAIL mask_merge got=%h exp=11bb33dd", beats[0]); end
   endtask

   task automatic test_back_to_back();
      int bad_valid, nv, bad_data, base, k, second;
      bit exp_v;
      bad_valid = 0; nv = 0; bad_data = 0; k = 0;
      second = L + B + 1;
      base = widx(32'h128) & ~(B - 1);
      @(negedge clk);
      bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h128;
      @(posedge clk);
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk); #1;
         exp_v = (n >= L + 1 && n <= L + B) || (n >= second + L + 1 && n <= second + L + B);
         if (bus.mem_rdata_valid !== exp_v) bad_valid++;
         if (bus.mem_rdata_valid === 1'b1) begin
            if (bus.mem_rdata !== ref_mem[base + (k % B)]) bad_data++;
            nv++; k++;
         end else if (bus.mem_rdata !== 32'h0) begin
            bad_data++;
         end
         if (n == second) begin
            @(negedge clk);
            bus.mem_ce = 1'b0;
         end
      end
      checks++;
      if (bad_valid !== 0) begin failures++; $display("FAIL b2b_valid_pattern got=%0d bad cycles exp=0", bad_valid); end
      checks++;
      if (nv !== 2 * B) begin failures++; $display("FAIL b2b_beats got=%0d exp=%0d", nv, 2 * B); end
      checks++;
      if (bad_data !== 0) begin failures++; $display("FAIL b2b_data got=%0d bad beats exp=0", bad_data); end
   endtask

   task automatic test_reset_mid();
      int lat, first, nv, seen; bit contig, clean; line_t beats;
      seen = 0;
      @(negedge clk);
      bus.mem_ce = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h128;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ce = 1'b0;
      for (int n = 1; n <= 30 && seen < 6; n++) begin
         @(posedge clk); #1;
         if (bus.mem_rdata_valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 6) begin failures++; $display("FAIL rstmid_reach_beat5 got=%0d beats exp=6", seen); end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.mem_rdata_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.mem_rdata_valid); end
      checks++;
      if (bus.mem_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", bus.mem_rdata); end
      @(negedge clk);
      reset = 1'b1;
      do_read(32'h128, beats, first, nv, contig, clean);
      checks++;
      if (nv !== B || first !== L + 1 || contig !== 1'b1) begin
         failures++; $display("FAIL rstmid_reread got=count%0d/first%0d/contig%0b exp=count%0d/first%0d/contig1", nv, first, contig, B, L + 1);
      end
      check_line("rstmid_reread", 32'h128, beats);
      // A write dropped while still waiting must leave memory untouched
      do_write(32'h300, 32'h01234567, 4'hF, lat);
      @(negedge clk);
      bus.mem_ce = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h300;
      bus.mem_wdata = 32'hCAFEF00D; bus.mem_wmask = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ce = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      do_read(32'h300, beats, first, nv, contig, clean);
      checks++;
      if (beats[0] !== 32'h01234567) begin failures++; $display("FAIL rstmid_wr_dropped got=%h exp=01234567", beats[0]); end
   endtask

   task automatic test_alias();
      int lat, first, nv; bit contig, clean; line_t beats;
      do_write((32'h1 << (DL + 2)) + 32'h8, 32'h5A5AA5A5, 4'hF, lat);
      do_read(32'h8, beats, first, nv, contig, clean);
      checks++;
      if (beats[2] !== 32'h5A5AA5A5) begin failures++; $display("FAIL alias_read got=%h exp=5a5aa5a5", beats[2]); end
      do_write(32'h8, 32'h0F0F0F0F, 4'h0, lat);
      checks++;
      if (lat !== L + 1) begin failures++; $display("FAIL zero_mask_resp got=%0d exp=%0d", lat, L + 1); end
      do_read(32'h8, beats, first, nv, contig, clean);
      checks++;
      if (beats[2] !== 32'h5A5AA5A5) begin failures++; $display("FAIL zero_mask_data got=%h exp=5a5aa5a5", beats[2]); end
   endtask

   task automatic test_random();
      int lat, first, nv; bit contig, clean; line_t beats;
      logic [31:0] a, d; logic [3:0] m;
      for (int i = 0; i < 128; i++) do_write(32'h400 + 32'(4*i), $urandom, 4'hF, lat);
      for (int t = 0; t < 30; t++) begin
         a = {$urandom_range(0, 1023) > 511 ? 18'($urandom) : 18'h0, 12'h100 + 12'($urandom_range(0, 127)), 2'($urandom)};
         d = $urandom;
         m = 4'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, d, m, lat);
            checks++;
            if (lat !== L + 1) begin failures++; $display("FAIL rnd_wr_latency op%0d got=%0d exp=%0d", t, lat, L + 1); end
         end else begin
            do_read(a, beats, first, nv, contig, clean);
            checks++;
            if (nv !== B || first !== L + 1 || contig !== 1'b1 || clean !== 1'b1) begin
               failures++; $display("FAIL rnd_rd_shape op%0d got=count%0d/first%0d/contig%0b/clean%0b exp=count%0d/first%0d/1/1", t, nv, first, contig, clean, B, L + 1);
            end
            check_line("rnd_rd", a, beats);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << DL); i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
      test_reset();
      test_write_read();
      test_burst();
      test_mask();
      test_back_to_back();
      test_reset_mid();
      test_alias();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog got=timeout exp=completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
